// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the signals between regfile_wb_arbiter and the parties around it:
// the pipeline writeback stage, the long-latency unit, the issue-stage
// scoreboard queries and the register-file write port.
//   master : the requesters and consumers around the arbiter
//   slave  : the arbiter itself
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
);
    localparam int unsigned AW = $clog2(NREG);

    // Writeback stage request (no backpressure)
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    // Long-latency request, held stable until accepted
    logic            ll_valid;
    logic [AW-1:0]   ll_addr;
    logic [XLEN-1:0] ll_data;
    logic            ll_ready;
    // Scoreboard set and queries
    logic            sb_set;
    logic [AW-1:0]   sb_addr;
    logic [AW-1:0]   chk_a1;
    logic [AW-1:0]   chk_a2;
    logic            busy1;
    logic            busy2;
    // Pipeline hold request and protocol error flag
    logic            pipe_stall;
    logic            err_stall_viol;
    // Register-file write port
    logic            rf_we;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd3;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output ll_valid, ll_addr, ll_data,
        input  ll_ready,
        output sb_set, sb_addr, chk_a1, chk_a2,
        input  busy1, busy2,
        input  pipe_stall, err_stall_viol,
        input  rf_we, rf_a3, rf_wd3
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  ll_valid, ll_addr, ll_data,
        output ll_ready,
        input  sb_set, sb_addr, chk_a1, chk_a2,
        output busy1, busy2,
        output pipe_stall, err_stall_viol,
        output rf_we, rf_a3, rf_wd3
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the in-order WB stage
// (always highest priority) and a long-latency unit. Keeps a busy scoreboard
// of pending long-latency destinations and stalls the pipeline when the
// long-latency requester has been refused STARVE_MAX cycles in a row.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : regfile_wb_arbiter_if slave modport (WB/LL requests, ll_ready,
//           scoreboard set/query, pipe_stall, err_stall_viol, rf write port)
module regfile_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned AW        = $clog2(NREG);
    localparam logic [3:0]  StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            pipe_stall_q;
    logic            err_q;
    logic            rf_we_q;
    logic [AW-1:0]   rf_a3_q;
    logic [XLEN-1:0] rf_wd3_q;
    logic [NREG-1:0] busy_q, busy_d;

    logic       ll_ready;
    logic       ll_hs;
    logic       ll_refused;
    logic [3:0] cnt_inc;

    // LL is accepted whenever WB is silent; held low while in reset.
    assign ll_ready   = reset & ~bus.wb_valid;
    assign ll_hs      = bus.ll_valid & ll_ready;
    assign ll_refused = bus.ll_valid & ~ll_ready;
    assign cnt_inc    = cnt_q + 4'd1;

    assign bus.ll_ready       = ll_ready;
    assign bus.pipe_stall     = pipe_stall_q;
    assign bus.err_stall_viol = err_q;
    assign bus.rf_we          = rf_we_q;
    assign bus.rf_a3          = rf_a3_q;
    assign bus.rf_wd3         = rf_wd3_q;
    assign bus.busy1          = (bus.chk_a1 != '0) & busy_q[bus.chk_a1];
    assign bus.busy2          = (bus.chk_a2 != '0) & busy_q[bus.chk_a2];

    // Clear for the accepted LL destination first, then set, so a same-cycle
    // set of the same register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        if (ll_hs) begin
            busy_d[bus.ll_addr] = 1'b0;
        end
        if (bus.sb_set && (bus.sb_addr != '0)) begin
            busy_d[bus.sb_addr] = 1'b1;
        end
    end

    // Write port, scoreboard and sticky protocol error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_q | (bus.wb_valid & pipe_stall_q);
            if (bus.wb_valid) begin
                rf_we_q  <= (bus.wb_addr != '0);
                rf_a3_q  <= bus.wb_addr;
                rf_wd3_q <= bus.wb_data;
            end else if (ll_hs) begin
                rf_we_q  <= (bus.ll_addr != '0);
                rf_a3_q  <= bus.ll_addr;
                rf_wd3_q <= bus.ll_data;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    // Starvation FSM; cnt_q counts consecutive refused LL cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pipe_stall_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ll_refused) begin
                        cnt_q <= 4'd1;
                        if (StarveMax == 4'd1) begin
                            state_q      <= StForce;
                            pipe_stall_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    // Dropping ll_valid here is illegal; recover to idle.
                    if (!bus.ll_valid || ll_hs) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == StarveMax) begin
                            state_q      <= StForce;
                            pipe_stall_q <= 1'b1;
                        end
                    end
                end
                StForce: begin
                    // A WB write here still wins; err_q records the violation.
                    if (!bus.ll_valid || ll_hs) begin
                        state_q      <= StIdle;
                        cnt_q        <= '0;
                        pipe_stall_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    cnt_q        <= '0;
                    pipe_stall_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (write_en/A3/WD3) between the in-order pipeline writeback stage and a long-latency unit (divider / load-miss return). Holds a destination scoreboard so the issue stage can detect RAW hazards on long-latency results. Enforces a starvation bound on the long-latency requester by stalling the pipeline. Sits between the WB stage, the long-latency unit and regfile.

Parameters:
XLEN, 32, data width of write data.
NREG, 32, number of architectural registers; address width AW = clog2(NREG) = 5.
STARVE_MAX, 4, consecutive cycles the LL port may be refused before a forced stall; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
wb_valid  in  1  pipeline WB write request; no backpressure, always highest priority.
wb_addr  in  AW  WB destination register.
wb_data  in  XLEN  WB write data.
ll_valid  in  1  long-latency write request; held with stable addr/data until accepted.
ll_addr  in  AW  LL destination register.
ll_data  in  XLEN  LL write data.
ll_ready  out  1  LL accepted this cycle when ll_valid & ll_ready.
sb_set  in  1  issue stage marks sb_addr busy (LL op issued).
sb_addr  in  AW  register to mark busy.
chk_a1  in  AW  scoreboard query 1 (source rs1).
chk_a2  in  AW  scoreboard query 2 (source rs2).
busy1  out  1  combinational: scoreboard bit for chk_a1; 0 when chk_a1 = 0.
busy2  out  1  combinational: scoreboard bit for chk_a2; 0 when chk_a2 = 0.
pipe_stall  out  1  registered request for the pipeline to hold WB (wb_valid must be 0 while high).
rf_we  out  1  registered regfile write enable.
rf_a3  out  AW  registered regfile write address.
rf_wd3  out  XLEN  registered regfile write data.
err_stall_viol  out  1  sticky: wb_valid seen high while pipe_stall high.

Behaviour:
- Reset (reset=0): rf_we=0, rf_a3=0, rf_wd3=0, ll_ready=0, pipe_stall=0, err_stall_viol=0, busy vector all 0, starvation counter 0, FSM in IDLE. Takes effect asynchronously, including mid-FORCE.
- Grant (combinational per cycle): wb_valid=1 -> WB wins, ll_ready=0. wb_valid=0 -> ll_ready=1 (out of reset).
- Write port latency: winner registered at edge N+1 as rf_we/rf_a3/rf_wd3. Regfile commits at edge N+2. No winner -> rf_we=0 (rf_a3/rf_wd3 hold).
- x0: any grant with addr 0 produces rf_we=0. LL handshake still completes. sb_set with sb_addr 0 ignored.
- Scoreboard: 32-bit busy vector. Set on sb_set. Cleared on the LL handshake edge for ll_addr. Set and clear to the same address in one cycle -> stays set. WB grants never touch the scoreboard.
- Starvation FSM:
  - IDLE: ll_valid & ~ll_ready -> WAIT, cnt=1.
  - WAIT: handshake -> IDLE, cnt=0. Still refused -> cnt+1. When cnt reaches STARVE_MAX -> FORCE, pipe_stall=1 from that edge.
  - FORCE: pipe_stall=1. LL handshake -> IDLE, pipe_stall=0 at that edge. wb_valid=1 in FORCE -> WB still wins, err_stall_viol set (sticky until reset), stay FORCE.
  - ll_valid dropping in WAIT or FORCE is illegal; FSM returns to IDLE, cnt=0.
- Simultaneous WB and LL to the same register: WB written first, LL next free cycle; LL value is final.

Test Plan:
- Reset: hold reset=0 with wb_valid=1 -> rf_we=0, busy1=busy2=0, pipe_stall=0, ll_ready=0. Release -> ll_ready=1 with wb_valid=0.
- WB write: wb_valid=1, wb_addr=1, wb_data=42 for one cycle -> next cycle rf_we=1, rf_a3=1, rf_wd3=42. Regfile read of x1 then returns 42.
- Collision: cycle N wb (x2, 100) and ll (x3, 200) both valid -> ll_ready=0 in N. rf writes x2=100 at N+1. ll_ready=1 in N+1. rf writes x3=200 at N+2.
- Starvation (STARVE_MAX=4): wb_valid held 1, ll_valid held (x4, 7) -> pipe_stall=1 after 4 refused cycles. Drop wb_valid -> handshake, pipe_stall=0 next edge, x4=7 written. Keep wb_valid=1 during FORCE -> err_stall_viol=1.
- Scoreboard: sb_set x5 -> busy1=1 with chk_a1=5, busy2=0 with chk_a2=6. LL handshake x5=200 -> busy1=0 after that edge. Repeat with sb_set x5 on the handshake cycle -> busy1 stays 1.
- x0 / reset mid-op: LL to x0 with 999 -> handshake completes, rf_we=0, x0 reads 0. Assert reset in FORCE with x5 busy -> pipe_stall=0, busy1=0, rf_we=0 immediately.
